// File: rtl/clk_div_prog.sv
// Runtime-programmable integer clock divider: registered divided waveform plus a period-start tick.
// Divisor/mode reloads are held pending and applied only at a period wrap, so no period is ever cut short.
module clk_div_prog #(
  parameter int WIDTH        = 8,
  parameter int DEFAULT_DIV  = 4,
  parameter int DEFAULT_MODE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             div_load,
  input  logic [WIDTH-1:0] div_in,
  input  logic             mode_in,
  output logic             ck_out,
  output logic             tick,
  output logic [WIDTH-1:0] div_cur,
  output logic             pend
);

  localparam int             HW       = WIDTH + 1;
  localparam logic [WIDTH-1:0] DEF_DIV  = WIDTH'(DEFAULT_DIV);
  localparam logic             DEF_MODE = (DEFAULT_MODE != 0);
  localparam logic [WIDTH-1:0] MIN_DIV  = WIDTH'(2);

  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] r_div;
  logic             r_mode;
  logic [WIDTH-1:0] r_div_p;
  logic             r_mode_p;
  logic             r_pend;
  logic             r_ck;
  logic             r_tick;

  logic [WIDTH-1:0] w_ld_div;
  logic             w_wrap;
  logic [WIDTH-1:0] w_div_nxt;
  logic             w_mode_nxt;
  logic [WIDTH-1:0] w_cnt_nxt;
  logic [HW-1:0]    w_high;

  assign w_ld_div  = (div_in < MIN_DIV) ? MIN_DIV : div_in;
  assign w_wrap    = en && (r_cnt == (r_div - WIDTH'(1)));
  assign w_cnt_nxt = w_wrap ? '0 : (r_cnt + WIDTH'(1));

  // A load landing on the wrap edge bypasses the pending register entirely.
  always_comb begin
    w_div_nxt  = r_div;
    w_mode_nxt = r_mode;
    if (w_wrap) begin
      if (div_load) begin
        w_div_nxt  = w_ld_div;
        w_mode_nxt = mode_in;
      end else if (r_pend) begin
        w_div_nxt  = r_div_p;
        w_mode_nxt = r_mode_p;
      end
    end
  end

  // High time uses the setting in effect after this edge; the extra bit keeps 2^WIDTH-1 exact.
  assign w_high = w_mode_nxt ? HW'(1) : (({1'b0, w_div_nxt} + HW'(1)) >> 1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= DEF_DIV - WIDTH'(1);
      r_div    <= DEF_DIV;
      r_mode   <= DEF_MODE;
      r_div_p  <= DEF_DIV;
      r_mode_p <= DEF_MODE;
      r_pend   <= 1'b0;
      r_ck     <= 1'b0;
      r_tick   <= 1'b0;
    end else begin
      if (div_load) begin
        r_div_p  <= w_ld_div;
        r_mode_p <= mode_in;
      end
      if (en) begin
        r_cnt  <= w_cnt_nxt;
        r_div  <= w_div_nxt;
        r_mode <= w_mode_nxt;
        r_ck   <= ({1'b0, w_cnt_nxt} < w_high);
      end
      r_tick <= w_wrap;
      r_pend <= w_wrap ? 1'b0 : (div_load ? 1'b1 : r_pend);
    end
  end

  assign ck_out  = r_ck;
  assign tick    = r_tick;
  assign div_cur = r_div;
  assign pend    = r_pend;

endmodule

// File: tb/tb_clk_div_prog.sv
// Directed vector bench for clk_div_prog: table of per-edge inputs and expected outputs,
// followed by a hand-written measurement of the maximum divisor period.
module tb_clk_div_prog;

  logic       clk;
  logic       rst;
  logic       en;
  logic       div_load;
  logic [7:0] div_in;
  logic       mode_in;
  logic       ck_out;
  logic       tick;
  logic [7:0] div_cur;
  logic       pend;

  int n_tests = 0;
  int n_fail  = 0;

  clk_div_prog #(.WIDTH(8), .DEFAULT_DIV(4), .DEFAULT_MODE(0)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .div_load (div_load),
    .div_in   (div_in),
    .mode_in  (mode_in),
    .ck_out   (ck_out),
    .tick     (tick),
    .div_cur  (div_cur),
    .pend     (pend)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       r;
    logic       e;
    logic       l;
    logic [7:0] d;
    logic       m;
    logic       ck;
    logic       tk;
    logic [7:0] dc;
    logic       pd;
  } vec_t;

  vec_t vq[$];

  task automatic v(input logic r, input logic e, input logic l, input logic [7:0] d,
                   input logic m, input logic ck, input logic tk, input logic [7:0] dc,
                   input logic pd);
    vec_t t;
    t.r = r; t.e = e; t.l = l; t.d = d; t.m = m;
    t.ck = ck; t.tk = tk; t.dc = dc; t.pd = pd;
    vq.push_back(t);
  endtask

  task automatic step(input vec_t t, input string name);
    @(negedge clk);
    rst = t.r; en = t.e; div_load = t.l; div_in = t.d; mode_in = t.m;
    @(posedge clk);
    #1;
    n_tests++;
    if ({ck_out, tick, div_cur, pend} !== {t.ck, t.tk, t.dc, t.pd}) begin
      n_fail++;
      $display("FAIL %s ck/tick/div/pend got %b/%b/%0d/%b expected %b/%b/%0d/%b",
               name, ck_out, tick, div_cur, pend, t.ck, t.tk, t.dc, t.pd);
    end
  endtask

  initial begin
    int len;
    int high;
    bit seen;
    vec_t t;

    rst = 1'b1; en = 1'b0; div_load = 1'b0; div_in = '0; mode_in = 1'b0;

    // Reset (second cycle also shows rst beating en and div_load), then default D=4.
    v(1,0,0,0,0, 0,0,4,0);
    v(1,1,1,9,1, 0,0,4,0);
    for (int i = 0; i < 8; i++) v(0,1,0,0,0, (i % 4) < 2, (i % 4) == 0, 4, 0);
    // Load D=5/M=0 mid-period: 11100 from the next wrap.
    v(0,1,0,0,0, 1,1,4,0);
    v(0,1,1,5,0, 1,0,4,1);
    v(0,1,0,0,0, 0,0,4,1);
    v(0,1,0,0,0, 0,0,4,1);
    v(0,1,0,0,0, 1,1,5,0);
    for (int i = 1; i < 5; i++) v(0,1,0,0,0, i < 3, 0, 5, 0);
    v(0,1,0,0,0, 1,1,5,0);
    // Load D=6/M=1: 100000.
    v(0,1,1,6,1, 1,0,5,1);
    v(0,1,0,0,0, 1,0,5,1);
    v(0,1,0,0,0, 0,0,5,1);
    v(0,1,0,0,0, 0,0,5,1);
    v(0,1,0,0,0, 1,1,6,0);
    for (int i = 1; i < 6; i++) v(0,1,0,0,0, 0,0,6,0);
    v(0,1,0,0,0, 1,1,6,0);
    // Clamp: load 0 then 1 -> D=2, pattern 10.
    v(0,1,1,0,0, 0,0,6,1);
    v(0,1,1,1,0, 0,0,6,1);
    for (int i = 0; i < 3; i++) v(0,1,0,0,0, 0,0,6,1);
    v(0,1,0,0,0, 1,1,2,0);
    v(0,1,0,0,0, 0,0,2,0);
    v(0,1,0,0,0, 1,1,2,0);
    v(0,1,0,0,0, 0,0,2,0);
    // Load on a wrap edge applies at once; pend never rises.
    v(0,1,1,4,0, 1,1,4,0);
    v(0,1,0,0,0, 1,0,4,0);
    v(0,1,0,0,0, 0,0,4,0);
    v(0,1,0,0,0, 0,0,4,0);
    v(0,1,1,3,0, 1,1,3,0);
    v(0,1,0,0,0, 1,0,3,0);
    v(0,1,0,0,0, 0,0,3,0);
    v(0,1,0,0,0, 1,1,3,0);
    // Two loads in one period: last one (9) wins.
    v(0,1,1,7,0, 1,0,3,1);
    v(0,1,1,9,0, 0,0,3,1);
    v(0,1,0,0,0, 1,1,9,0);
    for (int i = 1; i < 9; i++) v(0,1,0,0,0, i < 5, 0, 9, 0);
    v(0,1,0,0,0, 1,1,9,0);
    // Back to D=4, then freeze 3 cycles mid-high with a load during the freeze.
    v(0,1,1,4,0, 1,0,9,1);
    for (int i = 2; i < 9; i++) v(0,1,0,0,0, i < 5, 0, 9, 1);
    v(0,1,0,0,0, 1,1,4,0);
    v(0,1,0,0,0, 1,0,4,0);
    v(0,0,0,0,0, 1,0,4,0);
    v(0,0,1,2,1, 1,0,4,1);
    v(0,0,0,0,0, 1,0,4,1);
    v(0,1,0,0,0, 0,0,4,1);
    v(0,1,0,0,0, 0,0,4,1);
    v(0,1,0,0,0, 1,1,2,0);
    v(0,1,0,0,0, 0,0,2,0);
    v(0,1,0,0,0, 1,1,2,0);
    // Reach cnt=2 with a pending load, then reset.
    v(0,1,1,8,0, 0,0,2,1);
    v(0,1,0,0,0, 1,1,8,0);
    v(0,1,1,5,0, 1,0,8,1);
    v(0,1,0,0,0, 1,0,8,1);
    v(1,1,1,9,0, 0,0,4,0);
    for (int i = 0; i < 8; i++) v(0,1,0,0,0, (i % 4) < 2, (i % 4) == 0, 4, 0);

    for (int i = 0; i < vq.size(); i++) step(vq[i], $sformatf("vec[%0d]", i));

    // Maximum divisor: load 255 on the wrap edge, then measure one full period.
    t.r = 0; t.e = 1; t.l = 1; t.d = 8'd255; t.m = 0;
    t.ck = 1; t.tk = 1; t.dc = 8'd255; t.pd = 0;
    step(t, "max_load");
    @(negedge clk);
    div_load = 1'b0; div_in = '0;
    len  = 1;
    high = 1;
    seen = 1'b0;
    for (int c = 0; c < 600 && !seen; c++) begin
      @(posedge clk);
      #1;
      if (tick) seen = 1'b1;
      else begin
        len++;
        if (ck_out) high++;
      end
    end
    n_tests++;
    if (!seen) begin
      n_fail++;
      $display("FAIL max_period no tick within 600 cycles, expected one after 255");
    end else if (len != 255) begin
      n_fail++;
      $display("FAIL max_period got %0d expected 255", len);
    end
    n_tests++;
    if (high != 128) begin
      n_fail++;
      $display("FAIL max_high got %0d expected 128", high);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/clk_div_prog.md
# clk_div_prog

Runtime-programmable integer clock divider. It is the parametrised successor to the team's fixed divide-by-count block. It produces a registered divided clock-enable waveform `ck_out` and a one-cycle `tick` at the start of each output period. The divisor and duty mode can be reloaded on the fly, and the new setting takes effect glitch-free at the next period boundary. It sits in the clocking/timebase area and feeds baud generators, LED scanners and slow-strobe logic. `ck_out` is a logic signal in the `clk` domain and is never used as a clock net.

## Interface
- `WIDTH`, 8: width of divisor and internal counter; legal divisors are 2 .. 2^WIDTH-1.
- `DEFAULT_DIV`, 4: divisor active after reset; must be ≥ 2.
- `DEFAULT_MODE`, 0: duty mode after reset; 0 = near-50 %, 1 = single-cycle pulse.
- `clk` input 1: single clock. All logic is posedge `clk`.
- `rst` input 1: synchronous, active-high reset.
- `en` input 1: count enable. When low, the divider freezes.
- `div_load` input 1: one-cycle strobe that samples `div_in` and `mode_in` into the pending register.
- `div_in` input WIDTH: requested divisor D.
- `mode_in` input 1: requested duty mode.
- `ck_out` output 1: registered divided waveform.
- `tick` output 1: registered one-cycle strobe on each period start, i.e. the rising edge of `ck_out`.
- `div_cur` output WIDTH: divisor currently in effect.
- `pend` output 1: a loaded setting is waiting for the next period boundary.

## Operation
- State: counter `cnt` (WIDTH bits), active divisor D and mode M, pending divisor Dp and mode Mp, and `pend`.
- High time H:
  - M=0: H = ceil(D/2) = (D+1)>>1, computed at WIDTH+1 bits.
  - M=1: H = 1.
- Reset values: `cnt` = D-1 (so the first enabled cycle wraps), D = `DEFAULT_DIV`, M = `DEFAULT_MODE`, `ck_out` = 0, `tick` = 0, `pend` = 0, `div_cur` = `DEFAULT_DIV`.
- Each cycle with `en` = 1:
  - If `cnt` == D-1, this is a wrap. `cnt_next` = 0. If `pend` = 1 (or a load arrives this cycle), D←Dp and M←Mp, and `pend` clears.
  - Otherwise `cnt_next` = `cnt` + 1.
  - `ck_out` ← (`cnt_next` < H_next), where H_next is derived from the D/M in effect after this edge.
  - `tick` ← (`cnt_next` == 0).
- Each cycle with `en` = 0: `cnt`, `ck_out`, D and M hold. `tick` ← 0. Loads are still accepted into Dp/Mp and set `pend`.
- Load handling:
  - `div_load` = 1 writes Dp ← max(`div_in`, 2) and Mp ← `mode_in`. Values 0 and 1 clamp to 2.
  - `pend` ← 1, unless the same edge is an enabled wrap. In that case the new value is applied directly (bypassing Dp) and `pend` stays 0.
  - A repeated load before the wrap overwrites Dp/Mp; the last load wins.
- No mid-period change: D/M update only at a wrap, so no `ck_out` period is ever truncated or stretched.
- `rst` has priority over `en` and `div_load`. Reset mid-period discards any pending load and returns all state to reset values on the next edge.

## Timing
- Latency: the first edge after `rst` deasserts with `en` = 1 gives `ck_out` = 1 and `tick` = 1, i.e. 1 cycle from `en`.
- Steady state: period D cycles. `ck_out` is high H cycles, then low D-H cycles. `tick` rises in the same cycle as `ck_out`.
- Examples:
  - D=4, M=0: `ck_out` 1100 repeating.
  - D=5, M=0: 11100.
  - D=2: 10.
  - D=6, M=1: 100000.
- Setting change: a load at any point inside a period gives the first cycle of the new setting exactly on the next wrap. `div_cur` updates on that same edge.
- `en` deasserted for k cycles stretches the current period by exactly k cycles.
- The maximum divisor 2^WIDTH-1 must count without overflow. `cnt` never exceeds D-1.

## Test plan
- Reset/default: `rst` for 2 cycles, then `en` = 1 with D=4 → `ck_out` 1,1,0,0,1,1,… and `tick` at cycles 1, 5, 9. During reset, `ck_out` = `tick` = `pend` = 0 and `div_cur` = 4.
- Odd divisor and pulse mode: load D=5/M=0 → pattern 11100. Then load D=6/M=1 → pattern 100000, switching exactly at the wrap. `pend` is high from the load until that wrap.
- Clamp and bounds: load D=0, then D=1 → `div_cur` = 2 and pattern 10. With WIDTH=8, load D=255 → period 255 cycles and high time 128.
- Coincident events: load D=3 in the wrap cycle of D=4 → the next period is already 3 (110) and `pend` never asserts. Two loads (7 then 9) within one period → the new period is 9.
- Enable gating: with D=4, drop `en` for 3 cycles mid-high → `ck_out` holds high, `tick` = 0, and the period measures 7. A load during `en` = 0 applies at the first wrap after re-enable.
- Reset mid-operation: assert `rst` while `pend` = 1 and `cnt` = 2 → next edge gives `div_cur` = `DEFAULT_DIV`, `pend` = 0 and `ck_out` = 0. The sequence then restarts exactly as in the first test.
